// File: rtl/ln_pkg.sv
// Shared types and defaults for the fixed-point natural-logarithm unit.
// Build option LN_ROUND_EN selects round-half-up division instead of truncation.
package ln_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM   = 3'd1,
    PREP   = 3'd2,
    SERIES = 3'd3,
    DONE   = 3'd4
  } ln_state_e;

  typedef logic [63:0] ln_u64_t;

  localparam int unsigned LN_SCALE = 1000;
  localparam int unsigned LN_TERMS = 8;
  localparam int unsigned LN_LN2   = 693;

  function automatic ln_u64_t ln_div(input ln_u64_t num, input ln_u64_t den);
`ifdef LN_ROUND_EN
    return (num + (den >> 1)) / den;
`else
    return num / den;
`endif
  endfunction

endpackage

// File: rtl/ln_series_step.sv
// One atanh series term: accumulates p/(2i+1) and advances p by y^2.
// Division rounding follows LN_ROUND_EN through ln_pkg::ln_div.
module ln_series_step
  import ln_pkg::*;
#(
  parameter int unsigned SCALE = LN_SCALE,
  parameter int unsigned IW    = 3
) (
  input  ln_u64_t         p,
  input  ln_u64_t         y2,
  input  ln_u64_t         sum,
  input  logic [IW-1:0]   i,
  output ln_u64_t         p_next,
  output ln_u64_t         sum_next
);

  ln_u64_t odd_s;

  // Term divisor is the odd number 2i+1, formed by appending a one bit.
  always_comb begin
    odd_s    = 64'({i, 1'b1});
    sum_next = sum + ln_div(p, odd_s);
    p_next   = ln_div(p * y2, 64'(SCALE));
  end

endmodule

// File: rtl/ln_fixed.sv
// Sequential ln(x/SCALE)*SCALE: power-of-two normalisation then an atanh series.
// Build option LN_ROUND_EN rounds every division and the NORM halving shift.
module ln_fixed
  import ln_pkg::*;
#(
  parameter int unsigned SCALE = LN_SCALE,
  parameter int unsigned TERMS = LN_TERMS,
  parameter int unsigned LN2   = LN_LN2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err
);

  localparam int unsigned     IW       = (TERMS < 2) ? 1 : $clog2(TERMS);
  localparam logic [IW-1:0]   LAST_I   = IW'(TERMS - 1);
  localparam logic [31:0]     SCALE_W  = 32'(SCALE);
  localparam logic [31:0]     SCALE2_W = 32'(2 * SCALE);

  ln_state_e          state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic signed [5:0]  k_q, k_d;
  ln_u64_t            y2_q, y2_d;
  ln_u64_t            p_q, p_d;
  ln_u64_t            sum_q, sum_d;
  logic [IW-1:0]      i_q, i_d;
  logic [31:0]        result_q, result_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  ln_u64_t            y_s, y2_s;
  ln_u64_t            p_step_s, sum_step_s;
  logic [31:0]        half_s;

  ln_series_step #(
    .SCALE (SCALE),
    .IW    (IW)
  ) u_step (
    .p        (p_q),
    .y2       (y2_q),
    .sum      (sum_q),
    .i        (i_q),
    .p_next   (p_step_s),
    .sum_next (sum_step_s)
  );

  // Series seed from the normalised operand; only consumed in PREP, where x is in [SCALE, 2*SCALE).
  always_comb begin
    y_s  = ln_div(64'(x_q - SCALE_W) * 64'(SCALE), 64'(x_q) + 64'(SCALE));
    y2_s = ln_div(y_s * y_s, 64'(SCALE));
`ifdef LN_ROUND_EN
    half_s = 32'((33'(x_q) + 33'd1) >> 1);
`else
    half_s = x_q >> 1;
`endif
  end

  // Next-state and datapath update for the operation sequencer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    k_d         = k_q;
    y2_d        = y2_q;
    p_d         = p_q;
    sum_d       = sum_q;
    i_d         = i_q;
    result_d    = result_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = in_x;
          k_d        = 6'sd0;
          in_ready_d = 1'b0;
          state_d    = NORM;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      NORM: begin
        if (x_q == 32'd0) begin
          err_d       = 1'b1;
          result_d    = 32'h8000_0000;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (x_q >= SCALE2_W) begin
          x_d = half_s;
          k_d = k_q + 6'sd1;
        end else if (x_q < SCALE_W) begin
          x_d = x_q << 1;
          k_d = k_q - 6'sd1;
        end else begin
          state_d = PREP;
        end
      end
      PREP: begin
        y2_d    = y2_s;
        p_d     = y_s;
        sum_d   = 64'd0;
        i_d     = '0;
        state_d = SERIES;
      end
      SERIES: begin
        p_d   = p_step_s;
        sum_d = sum_step_s;
        i_d   = i_q + IW'(1);
        if (i_q == LAST_I) begin
          // k*LN2 is signed; the doubled series sum is small and non-negative.
          result_d    = 32'($signed(k_q) * $signed(32'(LN2))) + 32'(sum_step_s << 1);
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = SERIES;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= 32'd0;
      k_q         <= 6'sd0;
      y2_q        <= 64'd0;
      p_q         <= 64'd0;
      sum_q       <= 64'd0;
      i_q         <= '0;
      result_q    <= 32'd0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      k_q         <= k_d;
      y2_q        <= y2_d;
      p_q         <= p_d;
      sum_q       <= sum_d;
      i_q         <= i_d;
      result_q    <= result_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule
